// File: rtl/blink_bank.sv
// blink_bank: multi-channel LED blink generator.
// A shared free-running prescaler produces one tick every 2^CBITS cycles;
// each channel toggles its LED after (div_i+1) ticks while enabled.
// Optional counted-burst mode is compiled in with the BLINK_BURST_EN macro,
// which adds the start/burst_len/busy ports and a per-channel blink count.
module blink_bank #(
  parameter int unsigned CBITS     = 12,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DIVBITS   = 4,
  parameter int unsigned BURSTBITS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         en,
  input  logic [CHANNELS*DIVBITS-1:0] div,
`ifdef BLINK_BURST_EN
  input  logic [CHANNELS-1:0]         start,
  input  logic [BURSTBITS-1:0]        burst_len,
  output logic [CHANNELS-1:0]         busy,
`endif
  output logic [CHANNELS-1:0]         led,
  output logic                        flg
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Reject configurations outside the supported range at elaboration.
  if (CHANNELS < 1 || CHANNELS > 32 || CBITS < 1 || DIVBITS < 1 || BURSTBITS < 1) begin : g_bad_cfg
    $error("blink_bank: unsupported parameter set");
  end

  logic [CBITS-1:0] cnt;
  logic             tick;

  // The tick is the last count before the prescaler wraps.
  assign tick = &cnt;

  // Free-running prescaler and registered heartbeat flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      flg <= 1'b0;
    end else begin
      cnt <= cnt + CBITS'(1);
      flg <= tick;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t             st;
    state_t             st_nxt;
    logic [DIVBITS-1:0] sub;
    logic [DIVBITS-1:0] sub_nxt;
    logic [DIVBITS-1:0] dv;
    logic               led_q;
    logic               led_nxt;
    logic               wrap;
`ifdef BLINK_BURST_EN
    logic [BURSTBITS-1:0] rem;
    logic [BURSTBITS-1:0] rem_nxt;
    logic                 launch;
`endif

    assign dv   = div[i*DIVBITS +: DIVBITS];
    // >= rather than == so a divider lowered below sub still toggles next tick.
    assign wrap = (sub >= dv);
`ifdef BLINK_BURST_EN
    assign launch = start[i] && (burst_len != '0);
`endif

    // Channel state register.
    always_ff @(posedge clk) begin
      if (rst) begin
        st    <= ST_OFF;
        sub   <= '0;
        led_q <= 1'b0;
`ifdef BLINK_BURST_EN
        rem   <= '0;
`endif
      end else begin
        st    <= st_nxt;
        sub   <= sub_nxt;
        led_q <= led_nxt;
`ifdef BLINK_BURST_EN
        rem   <= rem_nxt;
`endif
      end
    end

    // Next-state logic: OFF/RUN/BURST transitions and tick-driven toggling.
    always_comb begin
      st_nxt  = st;
      sub_nxt = sub;
      led_nxt = led_q;
`ifdef BLINK_BURST_EN
      rem_nxt = rem;
`endif
      case (st)
        ST_OFF: begin
          sub_nxt = '0;
          led_nxt = 1'b0;
          if (en[i]) begin
            st_nxt = ST_RUN;
          end
`ifdef BLINK_BURST_EN
          else if (launch) begin
            st_nxt  = ST_BURST;
            rem_nxt = burst_len;
          end
`endif
        end
        ST_RUN: begin
          if (!en[i]) begin
            st_nxt  = ST_OFF;
            sub_nxt = '0;
            led_nxt = 1'b0;
          end else if (tick) begin
            if (wrap) begin
              sub_nxt = '0;
              led_nxt = ~led_q;
            end else begin
              sub_nxt = sub + DIVBITS'(1);
            end
          end
        end
`ifdef BLINK_BURST_EN
        ST_BURST: begin
          if (tick) begin
            if (wrap) begin
              sub_nxt = '0;
              led_nxt = ~led_q;
            end else begin
              sub_nxt = sub + DIVBITS'(1);
            end
          end
          if (en[i]) begin
            // Free-run takes over; the blink phase carries on uninterrupted.
            st_nxt  = ST_RUN;
            rem_nxt = '0;
          end else if (launch) begin
            rem_nxt = burst_len;
          end else if (tick && wrap && led_q) begin
            // Falling toggle completes one blink.
            if (rem == BURSTBITS'(1)) begin
              st_nxt  = ST_OFF;
              rem_nxt = '0;
              sub_nxt = '0;
              led_nxt = 1'b0;
            end else begin
              rem_nxt = rem - BURSTBITS'(1);
            end
          end
        end
`endif
        default: begin
          st_nxt  = ST_OFF;
          sub_nxt = '0;
          led_nxt = 1'b0;
        end
      endcase
    end

    // Outputs come straight from registered state.
    assign led[i] = led_q;
`ifdef BLINK_BURST_EN
    assign busy[i] = (st == ST_BURST);
`endif
  end

endmodule

// File: tb/tb_blink_bank.sv
// tb_blink_bank: directed bench for blink_bank with CBITS=2.
// A behavioural model (tick arithmetic, blink counting) runs alongside the
// DUT and is compared every cycle; literal expectations pin key edges.
module tb_blink_bank;
  localparam int CB  = 2;
  localparam int CH  = 4;
  localparam int DB  = 4;
  localparam int BB  = 8;
  localparam int PER = 1 << CB;

  logic           clk = 1'b0;
  logic           rst;
  logic [CH-1:0]  en;
  logic [CH*DB-1:0] div;
  logic [CH-1:0]  led;
  logic           flg;
`ifdef BLINK_BURST_EN
  logic [CH-1:0]  start;
  logic [BB-1:0]  burst_len;
  logic [CH-1:0]  busy;
`endif

  blink_bank #(.CBITS(CB), .CHANNELS(CH), .DIVBITS(DB), .BURSTBITS(BB)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .div(div),
`ifdef BLINK_BURST_EN
    .start(start),
    .burst_len(burst_len),
    .busy(busy),
`endif
    .led(led),
    .flg(flg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit chk_on = 1'b0;
  int e = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, e, $time);
  endtask

  // Behavioural model: mode 0=off 1=run 2=burst
  int mcnt;
  bit m_flg;
  int m_mode [CH];
  int m_t    [CH];
  int m_done [CH];
  int m_tgt  [CH];
  bit m_led  [CH];

  always @(posedge clk) begin
    bit tk;
    bit fell;
    int d;
    if (rst) begin
      mcnt  = 0;
      m_flg = 1'b0;
      for (int i = 0; i < CH; i++) begin
        m_mode[i] = 0; m_t[i] = 0; m_done[i] = 0; m_tgt[i] = 0; m_led[i] = 1'b0;
      end
    end else begin
      tk = ((mcnt % PER) == PER - 1);
      mcnt++;
      m_flg = tk;
      for (int i = 0; i < CH; i++) begin
        d = int'(div[i*DB +: DB]);
        if (m_mode[i] == 0) begin
          m_t[i] = 0;
          m_led[i] = 1'b0;
          if (en[i]) m_mode[i] = 1;
`ifdef BLINK_BURST_EN
          else if (start[i] && burst_len != 0) begin
            m_mode[i] = 2; m_done[i] = 0; m_tgt[i] = int'(burst_len);
          end
`endif
        end else if (m_mode[i] == 1 && !en[i]) begin
          m_mode[i] = 0; m_t[i] = 0; m_led[i] = 1'b0;
        end else begin
          fell = 1'b0;
          if (tk) begin
            m_t[i]++;
            if (m_t[i] > d) begin
              m_t[i] = 0;
              fell = m_led[i];
              m_led[i] = !m_led[i];
            end
          end
`ifdef BLINK_BURST_EN
          if (m_mode[i] == 2) begin
            if (en[i]) m_mode[i] = 1;
            else if (start[i] && burst_len != 0) m_tgt[i] = m_done[i] + int'(burst_len);
            else if (fell) begin
              m_done[i]++;
              if (m_done[i] >= m_tgt[i]) begin
                m_mode[i] = 0; m_led[i] = 1'b0; m_t[i] = 0;
              end
            end
          end
`endif
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [CH-1:0] mv;
    logic [CH-1:0] mb;
    if (chk_on) begin
      for (int i = 0; i < CH; i++) begin
        mv[i] = m_led[i];
        mb[i] = (m_mode[i] == 2);
      end
      chk("model_led", 32'(led), 32'(mv));
      chk("model_flg", 32'(flg), 32'(m_flg));
`ifdef BLINK_BURST_EN
      chk("model_busy", 32'(busy), 32'(mb));
`else
      chk("model_busy_none", 32'(mb), 32'd0);
`endif
    end
  end

  task automatic adv(input int k);
    while (e < k) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask

  // Drive rst for n edges; the last of them becomes edge 0.
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    e = 0;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    en  = '0;
    div = '0;
`ifdef BLINK_BURST_EN
    start = '0;
    burst_len = '0;
`endif
    // Reset / heartbeat
    do_reset(3);
    chk_on = 1'b1;
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_flg", 32'(flg), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      adv(k);
      chk("flg_early", 32'(flg), 32'd0);
    end
    adv(4);  chk("flg_e4", 32'(flg), 32'd1);
    adv(5);  chk("flg_e5", 32'(flg), 32'd0);
    adv(8);  chk("flg_e8", 32'(flg), 32'd1);
    adv(12); chk("flg_e12", 32'(flg), 32'd1);
    adv(13); chk("led_off_e13", 32'(led), 32'd0);

    // Basic blink, divider, mid-period change, disable
    en  = 4'b0011;
    div = {4'h0, 4'h0, 4'h2, 4'h0};
    do_reset(1);
    adv(4);  chk("led0_e4", 32'(led[0]), 32'd1);
    adv(8);  chk("led0_e8", 32'(led[0]), 32'd0);
    adv(11); chk("led1_e11", 32'(led[1]), 32'd0);
    adv(12); chk("led0_e12", 32'(led[0]), 32'd1);
             chk("led1_e12", 32'(led[1]), 32'd1);
    adv(17); div[DB +: DB] = 4'h0;
    adv(19); chk("led1_e19", 32'(led[1]), 32'd1);
    adv(20); chk("led1_lowered_e20", 32'(led[1]), 32'd0);
    adv(21); chk("led0_e21", 32'(led[0]), 32'd1);
             en[0] = 1'b0;
    adv(22); chk("led0_disabled_e22", 32'(led[0]), 32'd0);
    adv(24); chk("led1_e24", 32'(led[1]), 32'd1);
    adv(25); en[0] = 1'b1;
    adv(27); chk("led0_reen_e27", 32'(led[0]), 32'd0);
    adv(28); chk("led0_reen_e28", 32'(led[0]), 32'd1);
    adv(40);

`ifdef BLINK_BURST_EN
    // Counted burst
    en = '0;
    div = '0;
    burst_len = 8'd2;
    do_reset(1);
    adv(3);  start = 4'b0100;
             chk("busy_e3", 32'(busy), 32'd0);
    adv(4);  start = '0;
             chk("busy_e4", 32'(busy[2]), 32'd1);
    adv(8);  chk("bled_e8", 32'(led[2]), 32'd1);
    adv(12); chk("bled_e12", 32'(led[2]), 32'd0);
    adv(16); chk("bled_e16", 32'(led[2]), 32'd1);
    adv(19); chk("busy_e19", 32'(busy[2]), 32'd1);
    adv(20); chk("busy_e20", 32'(busy[2]), 32'd0);
             chk("bled_e20", 32'(led[2]), 32'd0);
    // Override by en
    adv(23); start = 4'b0100;
    adv(24); start = '0;
    adv(29); chk("busy_e29", 32'(busy[2]), 32'd1);
             en = 4'b0100;
    adv(30); chk("busy_override_e30", 32'(busy[2]), 32'd0);
    adv(32); chk("oled_e32", 32'(led[2]), 32'd0);
    adv(36); chk("oled_e36", 32'(led[2]), 32'd1);
    adv(37); en = '0;
    // Reset mid-burst
    adv(39); start = 4'b0100;
    adv(40); start = '0;
    adv(45); chk("rled_e45", 32'(led[2]), 32'd1);
             rst = 1'b1;
    adv(46); chk("rst_led", 32'(led), 32'd0);
             chk("rst_busy", 32'(busy), 32'd0);
             chk("rst_flg", 32'(flg), 32'd0);
             rst = 1'b0;
             e = 0;
    // Zero-length burst is ignored
    burst_len = 8'd0;
    start = 4'b1000;
    adv(1);  start = '0;
             chk("zero_len_busy", 32'(busy), 32'd0);
    adv(10);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
